// File: rtl/bicubic_pvector_mult_wmatrix_pipe.sv
// Signed N x N weight matrix times N-pixel vector -> per-row sign/magnitude with rounding and saturation.
// Two registered stages (products, then reduce/convert); valid/ready backpressure stalls both stages in place.
module bicubic_pvector_mult_wmatrix_pipe #(
   parameter int N            = 4,
   parameter int PIXEL_WIDTH  = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int OUT_WIDTH    = 15,
   parameter int OUT_SHIFT    = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wgt_load,
   input  logic [N*N*WEIGHT_WIDTH-1:0]     wgt_in,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [N*PIXEL_WIDTH-1:0]        pix_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [N*OUT_WIDTH-1:0]          out_mag,
   output logic [N-1:0]                    out_sign,
   output logic [N-1:0]                    out_sat
);

   localparam int PW = PIXEL_WIDTH + WEIGHT_WIDTH;
   localparam int SW = PW + $clog2(N);
   localparam int RW = SW + 1;
   // One spare bit above both the rounded magnitude and the output range keeps the compare exact.
   localparam int CW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;
   localparam int HS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic [CW-1:0] HALF = (OUT_SHIFT > 0) ? (CW'(1) << HS) : '0;
   localparam logic [CW-1:0] MAXV = {{(CW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   logic [N*N*WEIGHT_WIDTH-1:0] r_wgt;
   logic signed [PW-1:0]        r_prod [N*N];
   logic                        r_v1;
   logic                        r_v2;
   logic [N*OUT_WIDTH-1:0]      r_mag;
   logic [N-1:0]                r_sign;
   logic [N-1:0]                r_sat;

   logic signed [PW-1:0]        w_prod [N*N];
   logic [N*OUT_WIDTH-1:0]      w_mag;
   logic [N-1:0]                w_sign;
   logic [N-1:0]                w_sat;
   logic                        w_adv1;
   logic                        w_adv2;
   logic                        w_acc;

   assign w_adv2    = !r_v2 || out_ready;
   assign w_adv1    = w_adv2 || !r_v1;
   assign in_ready  = !r_v1 || !r_v2 || out_ready;
   assign w_acc     = in_valid && in_ready;
   assign out_valid = r_v2;
   assign out_mag   = r_mag;
   assign out_sign  = r_sign;
   assign out_sat   = r_sat;

   always_comb begin
      for (int i = 0; i < N*N; i++) begin
         w_prod[i] = PW'($signed(r_wgt[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]))
                   * PW'($signed(pix_in[(i % N)*PIXEL_WIDTH +: PIXEL_WIDTH]));
      end
   end

   always_comb begin : p_reduce
      logic signed [SW-1:0] v_acc;
      logic [SW-1:0]        v_abs;
      logic [CW-1:0]        v_rnd;
      w_mag  = '0;
      w_sign = '0;
      w_sat  = '0;
      v_acc  = '0;
      v_abs  = '0;
      v_rnd  = '0;
      for (int r = 0; r < N; r++) begin
         v_acc = '0;
         for (int c = 0; c < N; c++) begin
            v_acc = v_acc + SW'(r_prod[r*N+c]);
         end
         // The most negative sum negates onto itself, which is still the right unsigned magnitude.
         v_abs = v_acc[SW-1] ? -v_acc : v_acc;
         v_rnd = (CW'(v_abs) + HALF) >> OUT_SHIFT;
         w_sat[r]  = (v_rnd > MAXV);
         w_mag[r*OUT_WIDTH +: OUT_WIDTH] = w_sat[r] ? {OUT_WIDTH{1'b1}} : v_rnd[OUT_WIDTH-1:0];
         w_sign[r] = v_acc[SW-1] && (v_rnd != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wgt <= '0;
      end else if (wgt_load) begin
         r_wgt <= wgt_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         for (int i = 0; i < N*N; i++) r_prod[i] <= '0;
      end else if (w_adv1) begin
         r_v1 <= w_acc;
         if (w_acc) begin
            for (int i = 0; i < N*N; i++) r_prod[i] <= w_prod[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2   <= 1'b0;
         r_mag  <= '0;
         r_sign <= '0;
         r_sat  <= '0;
      end else if (w_adv2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_mag  <= w_mag;
            r_sign <= w_sign;
            r_sat  <= w_sat;
         end
      end
   end

endmodule

// File: tb/tb_bicubic_pvector_mult_wmatrix_pipe.sv
// Directed bench: table of weight/pixel vectors with hand-computed results, plus backpressure,
// simultaneous weight load and mid-stream reset sequences. Second instance uses OUT_SHIFT=2.
module tb_bicubic_pvector_mult_wmatrix_pipe;

   logic         clk;
   logic         rst_n;
   logic         wgt_load;
   logic [127:0] wgt_in;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  pix_in;
   logic         out_valid;
   logic         out_ready;
   logic [59:0]  out_mag;
   logic [3:0]   out_sign;
   logic [3:0]   out_sat;
   logic         rnd_in_ready;
   logic         rnd_out_valid;
   logic [59:0]  rnd_mag;
   logic [3:0]   rnd_sign;
   logic [3:0]   rnd_sat;

   int n_cmp = 0;
   int n_bad = 0;

   bicubic_pvector_mult_wmatrix_pipe dut (
      .clk(clk), .rst_n(rst_n), .wgt_load(wgt_load), .wgt_in(wgt_in),
      .in_valid(in_valid), .in_ready(in_ready), .pix_in(pix_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mag(out_mag), .out_sign(out_sign), .out_sat(out_sat)
   );

   bicubic_pvector_mult_wmatrix_pipe #(.OUT_SHIFT(2)) dut_rnd (
      .clk(clk), .rst_n(rst_n), .wgt_load(wgt_load), .wgt_in(wgt_in),
      .in_valid(in_valid), .in_ready(rnd_in_ready), .pix_in(pix_in),
      .out_valid(rnd_out_valid), .out_ready(out_ready),
      .out_mag(rnd_mag), .out_sign(rnd_sign), .out_sat(rnd_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] wgt;
      logic [63:0]  pix;
      logic [59:0]  mag;
      logic [3:0]   sgn;
      logic [3:0]   sat;
      logic [59:0]  rmag;
      logic [3:0]   rsgn;
      logic [3:0]   rsat;
   } vec_t;

   vec_t tbl [6];

   function automatic logic [31:0] mk4_8(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [63:0] mk4_16(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [59:0] mk4_15(input int a, input int b, input int c, input int d);
      return {15'(d), 15'(c), 15'(b), 15'(a)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [127:0] id_w, id2_w, all127_w, allm128_w, mix_w, edge_w;
   logic [59:0]  held;
   bit           have_held;
   int           idx;
   int           got[$];
   int           g;

   initial begin
      rst_n = 1'b0; wgt_load = 1'b0; wgt_in = '0;
      in_valid = 1'b0; pix_in = '0; out_ready = 1'b1;

      id_w      = {mk4_8(0,0,0,1), mk4_8(0,0,1,0), mk4_8(0,1,0,0), mk4_8(1,0,0,0)};
      id2_w     = {mk4_8(0,0,0,2), mk4_8(0,0,2,0), mk4_8(0,2,0,0), mk4_8(2,0,0,0)};
      all127_w  = {4{mk4_8(127,127,127,127)}};
      allm128_w = {4{mk4_8(-128,-128,-128,-128)}};
      mix_w     = {mk4_8(-1,-1,-1,-1), mk4_8(0,0,3,-3), mk4_8(2,-1,0,0), mk4_8(1,1,0,0)};
      edge_w    = {mk4_8(-1,-1,0,0), mk4_8(-1,0,0,0), mk4_8(1,1,0,0), mk4_8(1,0,0,0)};

      tbl[0] = '{id_w, mk4_16(10,-20,30,-40), mk4_15(10,20,30,40), 4'b1010, 4'b0000,
                 mk4_15(3,5,8,10), 4'b1010, 4'b0000};
      tbl[1] = '{all127_w, mk4_16(32767,32767,32767,32767), mk4_15(32767,32767,32767,32767),
                 4'b0000, 4'b1111, mk4_15(32767,32767,32767,32767), 4'b0000, 4'b1111};
      tbl[2] = '{id_w, mk4_16(6,-6,5,0), mk4_15(6,6,5,0), 4'b0010, 4'b0000,
                 mk4_15(2,2,1,0), 4'b0010, 4'b0000};
      tbl[3] = '{allm128_w, mk4_16(32767,32767,32767,32767), mk4_15(32767,32767,32767,32767),
                 4'b1111, 4'b1111, mk4_15(32767,32767,32767,32767), 4'b1111, 4'b1111};
      tbl[4] = '{mix_w, mk4_16(5,-5,7,100), mk4_15(0,15,279,107), 4'b1100, 4'b0000,
                 mk4_15(0,4,70,27), 4'b1100, 4'b0000};
      tbl[5] = '{edge_w, mk4_16(32767,1,0,0), mk4_15(32767,32767,32767,32767), 4'b1100, 4'b1010,
                 mk4_15(8192,8192,8192,8192), 4'b1100, 4'b0000};

      // Reset state
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_mag",       64'(out_mag),   64'd0);
      chk("rst_sign",      64'(out_sign),  64'd0);
      chk("rst_sat",       64'(out_sat),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Table-driven vectors
      for (int i = 0; i < 6; i++) begin
         wgt_load = 1'b1; wgt_in = tbl[i].wgt;
         step();
         wgt_load = 1'b0;
         in_valid = 1'b1; pix_in = tbl[i].pix;
         step();
         in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_lat1_valid", i), 64'(out_valid), 64'd0);
         step();
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d_mag",   i), 64'(out_mag),   64'(tbl[i].mag));
         chk($sformatf("v%0d_sign",  i), 64'(out_sign),  64'(tbl[i].sgn));
         chk($sformatf("v%0d_sat",   i), 64'(out_sat),   64'(tbl[i].sat));
         chk($sformatf("v%0d_rmag",  i), 64'(rnd_mag),   64'(tbl[i].rmag));
         chk($sformatf("v%0d_rsign", i), 64'(rnd_sign),  64'(tbl[i].rsgn));
         chk($sformatf("v%0d_rsat",  i), 64'(rnd_sat),   64'(tbl[i].rsat));
         step();
      end

      // Backpressure: five beats, downstream stalled for the first four cycles
      wgt_load = 1'b1; wgt_in = id_w;
      step();
      wgt_load = 1'b0;
      idx = 0; have_held = 0; held = '0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         in_valid  = (idx < 5);
         pix_in    = mk4_16(idx + 1, 0, 0, 0);
         out_ready = (cyc >= 4);
         @(negedge clk);
         if (cyc == 1) chk("bp_in_ready_c1", 64'(in_ready), 64'd1);
         if (cyc == 2) chk("bp_in_ready_c2", 64'(in_ready), 64'd0);
         if (cyc == 3) chk("bp_in_ready_c3", 64'(in_ready), 64'd0);
         if (cyc == 4) chk("bp_accepted_before_release", 64'(idx), 64'd2);
         if (out_valid && !out_ready) begin
            if (have_held) chk($sformatf("bp_stable_c%0d", cyc), 64'(out_mag), 64'(held));
            held = out_mag; have_held = 1;
         end
         if (out_valid && out_ready) begin
            got.push_back(int'(out_mag[14:0]));
            have_held = 0;
         end
         if (in_valid && in_ready) idx++;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_count", 64'(got.size()), 64'd5);
      for (int k = 0; k < 5; k++) begin
         g = (k < got.size()) ? got[k] : -1;
         chk($sformatf("bp_order_%0d", k), 64'(g), 64'(k + 1));
      end

      // Weight load in the same cycle as beat A; beat B follows
      wgt_load = 1'b1; wgt_in = id2_w;
      in_valid = 1'b1; pix_in = mk4_16(3,0,0,0);
      step();
      wgt_load = 1'b0;
      pix_in = mk4_16(3,0,0,0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("wl_a_valid", 64'(out_valid), 64'd1);
      chk("wl_a_mag",   64'(out_mag),   64'(mk4_15(3,0,0,0)));
      step();
      @(negedge clk);
      chk("wl_b_valid", 64'(out_valid), 64'd1);
      chk("wl_b_mag",   64'(out_mag),   64'(mk4_15(6,0,0,0)));
      step();

      // Reset with two beats in flight
      out_ready = 1'b0;
      in_valid = 1'b1; pix_in = mk4_16(1,1,1,1);
      step();
      pix_in = mk4_16(2,2,2,2);
      step();
      in_valid = 1'b0;
      #1;
      chk("mr_pre_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid",    64'(out_valid), 64'd0);
      chk("mr_in_ready", 64'(in_ready),  64'd1);
      chk("mr_mag",      64'(out_mag),   64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; pix_in = mk4_16(7,7,7,7);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mr_lat1_valid", 64'(out_valid), 64'd0);
      step();
      @(negedge clk);
      chk("mr_first_valid", 64'(out_valid), 64'd1);
      chk("mr_first_mag",   64'(out_mag),   64'd0);
      chk("mr_first_sign",  64'(out_sign),  64'd0);
      chk("mr_first_sat",   64'(out_sat),   64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge clk);
         chk($sformatf("mr_no_ghost_%0d", k), 64'(out_valid), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
